// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared mode encodings, FSM state type and default geometry
package tetris_pkg;

  localparam int DEF_FIELD_W = 20;
  localparam int DEF_FIELD_H = 20;
  localparam int DEF_BLK     = 4;

  localparam logic [1:0] MODE_CHECK   = 2'b00;
  localparam logic [1:0] MODE_MERGE   = 2'b01;
  localparam logic [1:0] MODE_OVERLAY = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/block_rotate_index.sv
// rtl/block_rotate_index.sv - maps a rotated block cell to its source bit, field index and OOB flag
module block_rotate_index #(
  parameter int FIELD_W = 20,
  parameter int FIELD_H = 20,
  parameter int BLK     = 4,
  parameter int POS_W   = 5,
  localparam int BW     = (BLK > 1) ? $clog2(BLK) : 1,
  localparam int SW     = (BLK * BLK > 1) ? $clog2(BLK * BLK) : 1,
  localparam int FW     = (FIELD_W * FIELD_H > 1) ? $clog2(FIELD_W * FIELD_H) : 1
) (
  input  logic [BW-1:0]    bx,
  input  logic [BW-1:0]    by,
  input  logic [1:0]       rotate,
  input  logic [POS_W-1:0] pos_x,
  input  logic [POS_W-1:0] pos_y,
  output logic [SW-1:0]    src_idx,
  output logic [FW-1:0]    field_idx,
  output logic             oob
);

  localparam int XW = POS_W + 1;

  // One extra bit so a block hanging off the right/bottom edge never wraps back in.
  logic [XW-1:0] x_ext;
  logic [XW-1:0] y_ext;

  assign x_ext = {1'b0, pos_x} + XW'(bx);
  assign y_ext = {1'b0, pos_y} + XW'(by);

  assign oob       = (int'(x_ext) >= FIELD_W) || (int'(y_ext) >= FIELD_H);
  assign field_idx = oob ? '0 : FW'(int'(y_ext) * FIELD_W + int'(x_ext));

  always_comb begin
    src_idx = '0;
    case (rotate)
      2'd0:    src_idx = SW'(int'(by) * BLK + int'(bx));
      2'd1:    src_idx = SW'((BLK - 1 - int'(bx)) * BLK + int'(by));
      2'd2:    src_idx = SW'((BLK - 1 - int'(by)) * BLK + (BLK - 1 - int'(bx)));
      default: src_idx = SW'(int'(bx) * BLK + (BLK - 1 - int'(by)));
    endcase
  end

endmodule

// File: rtl/field_merge_seq.sv
// rtl/field_merge_seq.sv - scans a rotated block one cell per clock and merges it into the playfield
module field_merge_seq
  import tetris_pkg::*;
#(
  parameter int FIELD_W = DEF_FIELD_W,
  parameter int FIELD_H = DEF_FIELD_H,
  parameter int BLK     = DEF_BLK,
  parameter int POS_W   = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic [POS_W-1:0]           block_pos_x,
  input  logic [POS_W-1:0]           block_pos_y,
  input  logic [1:0]                 rotate,
  input  logic [BLK*BLK-1:0]         block_matrix,
  input  logic [FIELD_W*FIELD_H-1:0] field_background,
  output logic                       busy,
  output logic                       done,
  output logic                       collision,
  output logic [FIELD_W*FIELD_H-1:0] field_out
);

  localparam int NCELL = BLK * BLK;
  localparam int NF    = FIELD_W * FIELD_H;
  localparam int KW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int BW    = (BLK > 1) ? $clog2(BLK) : 1;
  localparam int SW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int FW    = (NF > 1) ? $clog2(NF) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCELL - 1);

  state_t             state;
  logic [1:0]         mode_q;
  logic [1:0]         rot_q;
  logic [POS_W-1:0]   px_q;
  logic [POS_W-1:0]   py_q;
  logic [NCELL-1:0]   blk_q;
  logic [NF-1:0]      bg_q;
  logic [NF-1:0]      work;
  logic               coll;
  logic               oob_f;
  logic [KW-1:0]      k;

  logic [BW-1:0]      bx;
  logic [BW-1:0]      by;
  logic [SW-1:0]      src_idx;
  logic [FW-1:0]      fidx;
  logic               cell_oob;

  assign bx = BW'(int'(k) % BLK);
  assign by = BW'(int'(k) / BLK);

  block_rotate_index #(
    .FIELD_W (FIELD_W),
    .FIELD_H (FIELD_H),
    .BLK     (BLK),
    .POS_W   (POS_W)
  ) u_index (
    .bx        (bx),
    .by        (by),
    .rotate    (rot_q),
    .pos_x     (px_q),
    .pos_y     (py_q),
    .src_idx   (src_idx),
    .field_idx (fidx),
    .oob       (cell_oob)
  );

  logic          cell_set;
  logic          coll_nx;
  logic          oob_nx;
  logic [NF-1:0] work_nx;

  // Next-cycle view including the current cell, so the last cell lands on the done edge.
  always_comb begin
    cell_set = blk_q[src_idx];
    work_nx  = work;
    coll_nx  = coll;
    oob_nx   = oob_f;
    if (cell_set) begin
      if (cell_oob)
        oob_nx = 1'b1;
      else if (bg_q[fidx])
        coll_nx = 1'b1;
      else
        work_nx[fidx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode_q    <= '0;
      rot_q     <= '0;
      px_q      <= '0;
      py_q      <= '0;
      blk_q     <= '0;
      bg_q      <= '0;
      work      <= '0;
      coll      <= 1'b0;
      oob_f     <= 1'b0;
      k         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      collision <= 1'b0;
      field_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q <= mode;
            rot_q  <= rotate;
            px_q   <= block_pos_x;
            py_q   <= block_pos_y;
            blk_q  <= block_matrix;
            bg_q   <= field_background;
            work   <= field_background;
            coll   <= 1'b0;
            oob_f  <= 1'b0;
            k      <= '0;
            busy   <= 1'b1;
            state  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          work  <= work_nx;
          coll  <= coll_nx;
          oob_f <= oob_nx;
          k     <= k + 1'b1;
          if (k == K_LAST) begin
            state     <= ST_DONE;
            done      <= 1'b1;
            collision <= coll_nx | oob_nx;
            case (mode_q)
              MODE_MERGE:   field_out <= (coll_nx | oob_nx) ? bg_q : work_nx;
              MODE_OVERLAY: field_out <= work_nx;
              default:      field_out <= field_out;
            endcase
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
